// File: rtl/scanline_reader_pkg.sv
// Shared GPU scanline definitions: line geometry, reader state encoding and
// the 2-bit colour index type consumed by the palette stage.
package scanline_reader_pkg;

  localparam int SL_LINE_BYTES      = 20;
  localparam int SL_PIXELS_PER_LINE = 8 * SL_LINE_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } sl_state_e;

  typedef logic [1:0] color_idx_t;

endpackage

// File: rtl/scanline_reader_if.sv
// Pixel stream from the scanline reader to the palette/LCD stage.
// The reader is the master; the palette lookup is the slave.
interface scanline_reader_if #(
  parameter int X_W = 8
) ();
  import scanline_reader_pkg::*;

  color_idx_t     px_data;
  logic [X_W-1:0] px_x;
  logic           px_valid;
  logic           px_ready;

  modport master (output px_data, output px_x, output px_valid, input px_ready);
  modport slave  (input px_data, input px_x, input px_valid, output px_ready);

endinterface

// File: rtl/scanline_reader_bitplane_shifter.sv
// Dual 8-bit load/shift register for the low and high bitplanes; presents
// the current MSB pair as a colour index {hi[7], lo[7]}.
module scanline_bitplane_shifter
  import scanline_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [7:0] i_lo,
  input  logic [7:0] i_hi,
  output color_idx_t o_px
);

  logic [7:0] r_lo;
  logic [7:0] r_hi;

  // Load has priority: a reload replaces the byte that has just been drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= 8'h00;
      r_hi <= 8'h00;
    end else if (i_load) begin
      r_lo <= i_lo;
      r_hi <= i_hi;
    end else if (i_shift) begin
      r_lo <= {r_lo[6:0], 1'b0};
      r_hi <= {r_hi[6:0], 1'b0};
    end
  end

  assign o_px = {r_hi[7], r_lo[7]};

endmodule

// File: rtl/scanline_reader.sv
// Read side of the scanline buffer pair: fetches one line of low/high plane
// bytes and streams it out MSB-first as 2-bit colour indices.
module scanline_reader
  import scanline_reader_pkg::*;
#(
  parameter int LINE_BYTES = SL_LINE_BYTES,
  parameter int ADDR_W     = 5,
  parameter int X_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_lo_addr,
  input  logic [7:0]        i_lo_data,
  output logic [ADDR_W-1:0] o_hi_addr,
  input  logic [7:0]        i_hi_data,
  output logic              o_busy,
  output logic              o_line_done,
  scanline_reader_if.master px
);

  sl_state_e         r_state;
  sl_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [2:0]        r_bit_cnt;
  logic [X_W-1:0]    r_px_x;
  logic              w_load;
  logic              w_shift;
  logic              w_clear;
  logic              w_hs;
  logic              w_last;
  color_idx_t        w_px;

  // Next-state and datapath enables; the reload on the eighth bit keeps the
  // pixel stream free of bubbles between bytes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_hs        = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_hs = px.px_ready;
        if (!w_hs) begin
          w_state_nxt = ST_SHIFT;
        end else if (r_bit_cnt != 3'd7) begin
          w_shift = 1'b1;
        end else if (r_rd_idx != ADDR_W'(LINE_BYTES)) begin
          w_load = 1'b1;
        end else begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counters; px_x stops at the last pixel rather than running past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rd_idx  <= '0;
      r_bit_cnt <= 3'd0;
      r_px_x    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_rd_idx  <= '0;
        r_bit_cnt <= 3'd0;
        r_px_x    <= '0;
      end else begin
        if (w_load) begin
          r_rd_idx <= r_rd_idx + ADDR_W'(1);
        end
        if (w_hs) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (!w_last) begin
            r_px_x <= r_px_x + X_W'(1);
          end
        end
      end
    end
  end

  scanline_bitplane_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_lo    (i_lo_data),
    .i_hi    (i_hi_data),
    .o_px    (w_px)
  );

  assign o_lo_addr   = r_rd_idx;
  assign o_hi_addr   = r_rd_idx;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_line_done = (r_state == ST_DONE);
  assign px.px_valid = (r_state == ST_SHIFT);
  assign px.px_data  = w_px;
  assign px.px_x     = r_px_x;

endmodule

// File: tb/tb_scanline_reader.sv
// Scoreboard bench for scanline_reader: a golden pixel list is queued at each
// start and consumed by a negedge monitor as the DUT presents pixels.
module tb_scanline_reader;
  import scanline_reader_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] lo_addr;
  logic [4:0] hi_addr;
  logic [7:0] lo_data;
  logic [7:0] hi_data;
  logic       busy;
  logic       line_done;

  logic [7:0] lo_mem [0:31];
  logic [7:0] hi_mem [0:31];

  logic [9:0] sb_q [$];
  int n_pass;
  int n_total;
  int n_done;

  scanline_reader_if #(.X_W(8)) px_if ();

  scanline_reader #(.LINE_BYTES(20), .ADDR_W(5), .X_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .o_lo_addr   (lo_addr),
    .i_lo_data   (lo_data),
    .o_hi_addr   (hi_addr),
    .i_hi_data   (hi_data),
    .o_busy      (busy),
    .o_line_done (line_done),
    .px          (px_if.master)
  );

  assign lo_data = lo_mem[lo_addr];
  assign hi_data = hi_mem[hi_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every presented pixel must equal the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      n_total++;
      if (hi_addr !== lo_addr) $display("FAIL addr_equal hi=%0d lo=%0d", hi_addr, lo_addr);
      else n_pass++;
      if (px_if.px_valid) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_pixel got data=%b x=%0d, expected none", px_if.px_data, px_if.px_x);
        end else if ({px_if.px_data, px_if.px_x} !== sb_q[0]) begin
          $display("FAIL pixel got data=%b x=%0d, expected data=%b x=%0d",
                   px_if.px_data, px_if.px_x, sb_q[0][9:8], sb_q[0][7:0]);
        end else begin
          n_pass++;
        end
        if (px_if.px_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
      if (line_done) begin
        n_done++;
        n_total++;
        if (sb_q.size() != 0) $display("FAIL done_early got %0d pixels left, expected 0", sb_q.size());
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line();
    for (int p = 0; p < SL_PIXELS_PER_LINE; p++) begin
      logic [7:0] lb;
      logic [7:0] hb;
      int bp;
      lb = lo_mem[p / 8];
      hb = hi_mem[p / 8];
      bp = 7 - (p % 8);
      sb_q.push_back({hb[bp], lb[bp], 8'(p)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    px_if.px_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_total++;
    if ({px_if.px_valid, busy, line_done, px_if.px_data, px_if.px_x, lo_addr, hi_addr} !== 23'd0)
      $display("FAIL reset_state got valid=%b busy=%b done=%b data=%b x=%0d lo=%0d hi=%0d, expected all 0",
               px_if.px_valid, busy, line_done, px_if.px_data, px_if.px_x, lo_addr, hi_addr);
    else n_pass++;
  endtask

  task automatic test_first_byte();
    int edges;
    for (int k = 0; k < 32; k++) begin
      lo_mem[k] = 8'($urandom);
      hi_mem[k] = 8'($urandom);
    end
    lo_mem[0] = 8'hF0;
    hi_mem[0] = 8'h0F;
    n_done = 0;
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!line_done && edges < 400) begin
      tick();
      edges++;
    end
    n_total++;
    if (edges !== 162) $display("FAIL first_latency got %0d edges, expected 162", edges);
    else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0 || n_done !== 1) $display("FAIL first_idle got busy=%b dones=%0d, expected 0 and 1", busy, n_done);
    else n_pass++;
  endtask

  task automatic test_full_line();
    int cyc;
    int gaps;
    int addr_bad;
    bit seen;
    for (int k = 0; k < 20; k++) begin
      lo_mem[k] = 8'(k);
      hi_mem[k] = ~8'(k);
    end
    n_done = 0;
    gaps = 0;
    addr_bad = 0;
    seen = 1'b0;
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!line_done && cyc < 400) begin
      if (px_if.px_valid) begin
        seen = 1'b1;
        if (int'(lo_addr) != int'(px_if.px_x) / 8 + 1) addr_bad++;
      end else if (seen) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    n_total++;
    if (!line_done || gaps != 0 || addr_bad != 0)
      $display("FAIL full_line got done=%b gaps=%0d addr_errs=%0d, expected 1/0/0", line_done, gaps, addr_bad);
    else n_pass++;
    tick();
  endtask

  task automatic test_random_ready();
    int cyc;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      lo_mem[k] = 8'($urandom);
      hi_mem[k] = 8'($urandom);
    end
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!line_done && cyc < 2000) begin
      px_if.px_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    px_if.px_ready = 1'b1;
    repeat (3) tick();
    n_total++;
    if (n_done !== 1 || sb_q.size() != 0)
      $display("FAIL random_ready got dones=%0d left=%0d, expected 1 and 0", n_done, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int cyc;
    n_done = 0;
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(px_if.px_valid && px_if.px_x == 8'd50) && cyc < 400) begin
      tick();
      cyc++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || px_if.px_x !== 8'd51) $display("FAIL start_mid got busy=%b x=%0d, expected 1 and 51", busy, px_if.px_x);
    else n_pass++;
    while (!line_done && cyc < 400) begin
      tick();
      cyc++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0 || n_done !== 1) $display("FAIL start_in_done got busy=%b dones=%0d, expected 0 and 1", busy, n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    n_done = 0;
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(px_if.px_valid && px_if.px_x == 8'd83) && cyc < 400) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    tick();
    n_total++;
    if (px_if.px_valid !== 1'b0 || busy !== 1'b0 || px_if.px_x !== 8'd0 || lo_addr !== 5'd0 || line_done !== 1'b0)
      $display("FAIL reset_mid got valid=%b busy=%b x=%0d lo=%0d done=%b, expected 0/0/0/0/0",
               px_if.px_valid, busy, px_if.px_x, lo_addr, line_done);
    else n_pass++;
    rst = 1'b0;
    sb_q.delete();
    tick();
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!line_done && cyc < 400) begin
      tick();
      cyc++;
    end
    tick();
    n_total++;
    if (n_done !== 1 || sb_q.size() != 0) $display("FAIL after_reset got dones=%0d left=%0d, expected 1 and 0", n_done, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_long_stall();
    int cyc;
    int bad;
    logic [7:0] lb;
    logic [7:0] hb;
    n_done = 0;
    bad = 0;
    push_line();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(px_if.px_valid && px_if.px_x == 8'd15) && cyc < 400) begin
      tick();
      cyc++;
    end
    px_if.px_ready = 1'b0;
    repeat (100) begin
      tick();
      if (!px_if.px_valid || px_if.px_x != 8'd15) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stall_hold got %0d bad cycles, expected 0", bad);
    else n_pass++;
    px_if.px_ready = 1'b1;
    tick();
    lb = lo_mem[2];
    hb = hi_mem[2];
    n_total++;
    if (px_if.px_valid !== 1'b1 || px_if.px_x !== 8'd16 || px_if.px_data !== {hb[7], lb[7]})
      $display("FAIL stall_release got valid=%b x=%0d data=%b, expected 1 16 %b",
               px_if.px_valid, px_if.px_x, px_if.px_data, {hb[7], lb[7]});
    else n_pass++;
    while (!line_done && cyc < 800) begin
      tick();
      cyc++;
    end
    tick();
    n_total++;
    if (n_done !== 1 || busy !== 1'b0) $display("FAIL stall_done got dones=%0d busy=%b, expected 1 and 0", n_done, busy);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    n_done = 0;
    for (int k = 0; k < 32; k++) begin
      lo_mem[k] = 8'hA5;
      hi_mem[k] = 8'h5A;
    end
    test_reset();
    test_first_byte();
    test_full_line();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    test_long_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scanline_reader.md
Name: scanline_reader

Overview:
- Read side of the scanline buffer pair. Reads one line's low-plane and high-plane bytes from two 20-byte scanline RAMs.
- Serializes them MSB-first into 160 two-bit colour indices.
- Hands the pixels to the palette/LCD stage over a valid/ready handshake.
- Sits between the scanline RAMs, which have asynchronous read ports, and the palette lookup. One `start` per line.

Parameters:
- LINE_BYTES, 20, bytes per bitplane per line (pixels per line = 8*LINE_BYTES).
- ADDR_W, 5, scanline RAM address width; must satisfy 2^ADDR_W >= LINE_BYTES.
- X_W, 8, pixel x-coordinate width; must satisfy 2^X_W >= 8*LINE_BYTES.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to scan out a line; honoured only in IDLE.
- lo_addr  out  ADDR_W  address to low-plane scanline RAM.
- lo_data  in  8  combinational read data from low-plane RAM.
- hi_addr  out  ADDR_W  address to high-plane scanline RAM; always equal to lo_addr.
- hi_data  in  8  combinational read data from high-plane RAM.
- px_data  out  2  colour index {hi_bit, lo_bit}.
- px_x  out  X_W  x coordinate of px_data, 0..159.
- px_valid  out  1  px_data/px_x valid.
- px_ready  in  1  downstream accepts when px_valid && px_ready.
- busy  out  1  high in any state other than IDLE.
- line_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Registers:
  - lo_sr, hi_sr: 8-bit shift registers.
  - rd_idx: ADDR_W bits, the next byte to fetch.
  - bit_cnt: 3 bits.
  - px_x counter.
  - 2-bit state.
- lo_addr = hi_addr = rd_idx, registered value, no combinational path from inputs.
- Reset:
  - state = IDLE; rd_idx, bit_cnt, px_x, lo_sr, hi_sr = 0.
  - Outputs: px_valid = 0, busy = 0, line_done = 0, px_data = 0, px_x = 0, addresses = 0.
- State IDLE:
  - px_valid = 0.
  - If start: rd_idx <= 0, px_x <= 0, bit_cnt <= 0, go to LOAD.
- State LOAD (one cycle):
  - Latch lo_sr <= lo_data, hi_sr <= hi_data.
  - rd_idx <= rd_idx + 1.
  - Go to SHIFT.
- State SHIFT:
  - px_valid = 1; px_data = {hi_sr[7], lo_sr[7]}.
  - On handshake:
    - px_x <= px_x + 1; bit_cnt <= bit_cnt + 1.
    - If bit_cnt != 7: shift both registers left by one, zero fill.
    - If bit_cnt == 7 and rd_idx != LINE_BYTES: reload lo_sr/hi_sr from RAM data at rd_idx, rd_idx++, stay in SHIFT. No bubble.
    - If bit_cnt == 7 and rd_idx == LINE_BYTES: go to DONE.
  - With no handshake: all state holds; px_data/px_x stay stable while px_valid && !px_ready.
- State DONE (one cycle):
  - line_done = 1, px_valid = 0.
  - Go to IDLE.
- Latency:
  - start sampled at edge N → LOAD during cycle N..N+1 → px_valid high after edge N+1.
  - With px_ready held high, a line takes 1 + 160 + 1 = 162 cycles from start to return to IDLE.
- start while busy: ignored, no restart and no queueing.
- start in the same cycle as line_done (DONE state): ignored; must be reissued in IDLE.
- rst mid-line: immediate return to the reset values above; no line_done.
- RAM contents must be stable from start until line_done; the writer is blocked by the caller, not by this block.
- px_x wraps nowhere: the maximum value produced is 159, and it is reset to 0 only on start.

Decomposition:
- Shared GPU package holds:
  - LINE_BYTES = 20 and PIXELS_PER_LINE = 160.
  - Scanline state encoding IDLE/LOAD/SHIFT/DONE.
  - 2-bit colour-index type shared with the palette stage.
- One natural sub-module: scanline_bitplane_shifter, a dual 8-bit load/shift register with {hi[7], lo[7]} output and load/shift enables. It is instantiated once.
- Control FSM and counters remain in scanline_reader.

Test Plan:
- Reset then start, px_ready=1; RAM lo[0]=8'hF0, hi[0]=8'h0F → first 8 pixels 2'b01 ×4 then 2'b10 ×4, px_x 0..7; line_done exactly 162 cycles after start; busy low the next cycle.
- Full line with lo[k]=k, hi[k]=~k, k=0..19 → 160 pixels match the golden model; px_x increments 0..159; lo_addr sequence 0..19 each once; no px_valid gap after the first pixel.
- Random px_ready (50%) → px_data/px_x hold while stalled; same 160-pixel sequence; no pixel duplicated or dropped; line_done only after pixel 159 is accepted.
- start asserted again at pixel 50 and during DONE → ignored; pixel stream continues unchanged; single line_done.
- rst asserted at pixel 83 with px_ready=1 → next cycle px_valid=0, busy=0, px_x=0, lo_addr=0, no line_done; a subsequent start produces a full correct line.
- px_ready held low for 100 cycles at a byte boundary (bit_cnt=7) → pixel 7 of byte k stays presented; on release, pixel 8 comes from byte k+1 the following cycle.
